pwr_rst_seq: RTL
================

// Module: pwr_rst_seq
// PURPOSE
//  Multi-channel power-on reset sequencer; parametrised successor to the single-output power-on reset.
//  Waits for clock-source lock, then releases CHANNEL_NUM reset outputs in order, channel 0 first.
//  Channel i releases after BASE delay + i*STEP delay. Loss of lock re-asserts all channels and restarts.
//  Sits at top level next to the PLL; drives per-subsystem resets (DDS, ADC, interfaces...).
// PARAMETERS
//  MAIN_CLOCK_PERIOD    7          clk period in ns (integer)
//  CHANNEL_NUM          4          number of reset outputs, 1..16
//  PWR_RST_DELAY        100000000  ns from lock to channel 0 release
//  PWR_RST_STEP         1000000    ns between consecutive channel releases
//  PWR_RST_ACTIVE_LEVEL 0          [CHANNEL_NUM-1:0] per-channel active level, bit i -> channel i
// PORTS
//  clk        input   1            main clock
//  rst_n      input   1            asynchronous active-low reset
//  locked     input   1            clock-source lock, asynchronous to clk
//  rst_out    output  CHANNEL_NUM  sequenced resets, bit i uses PWR_RST_ACTIVE_LEVEL[i]
//  done       output  1            high once all channels released
//  soft_rst_req input 1            present only with PWR_RST_SOFT_EN, synchronous, level
// BEHAVIOUR
//  - Async reset (rst_n=0): rst_out = PWR_RST_ACTIVE_LEVEL, done=0, state=S_WAIT_LOCK,
//    count=0, lock synchroniser flops=0. Release is clock-synchronous.
//  - locked passes through a 2-flop synchroniser -> lock_s; only lock_s is used.
//  - Derived: BASE_CNT = PWR_RST_DELAY/MAIN_CLOCK_PERIOD; STEP_CNT = PWR_RST_STEP/MAIN_CLOCK_PERIOD;
//    thr_i = BASE_CNT + i*STEP_CNT. Integer division truncates. 32-bit unsigned arithmetic.
//  - States:
//    S_WAIT_LOCK : all rst_out active, done=0, count held at 0.
//                  lock_s=1 -> S_COUNT.
//    S_COUNT     : count increments by 1 per edge and saturates at 2^32-1 (no wrap).
//                  At each edge, rst_out[i] <= inactive if sampled count >= thr_i, otherwise active.
//                  Once released, a channel stays released while in S_COUNT/S_DONE.
//                  Edge that releases the last channel -> S_DONE and done=1 on the same edge.
//    S_DONE      : outputs held, count frozen, done=1.
//  - Latency: channel i releases thr_i+1 edges after entering S_COUNT, i.e. thr_i+3 edges after
//    the first edge that samples locked=1. thr_i=0 releases on the first S_COUNT edge.
//  - Equal thresholds (STEP_CNT=0): all channels release on the same edge.
//  - lock_s=0 in S_COUNT or S_DONE: next edge -> S_WAIT_LOCK, all rst_out active, done=0, count=0.
//  - A lock glitch shorter than 1 clk may be missed by the synchroniser; no filtering is done.
//  - rst_n asserted mid-sequence aborts immediately (async); the sequence restarts from 0.
//  - Every output is registered; there is no combinational path from any input to an output.
// CONFIGURATION
//  PWR_RST_SOFT_EN defined:
//    adds soft_rst_req. soft_rst_req=1 sampled in S_COUNT or S_DONE -> same effect as loss of lock.
//    Stays in S_WAIT_LOCK while soft_rst_req=1, even with lock_s=1.
//    Sequence restarts on the first edge with soft_rst_req=0 and lock_s=1.
//  PWR_RST_SOFT_EN undefined:
//    port absent; only rst_n and locked can restart the sequence.
// TESTING  (MAIN_CLOCK_PERIOD=10, PWR_RST_DELAY=100, PWR_RST_STEP=50, CHANNEL_NUM=4, ACTIVE_LEVEL=4'b0101)
//  1 rst_n=0 with locked=1 -> rst_out=4'b0101, done=0 throughout; nothing changes during reset.
//  2 rst_n released, locked=1 before edge 0 -> thr=10,15,20,25.
//    ch0..ch3 toggle at edges 13,18,23,28; done=1 at edge 28; final rst_out=4'b1010.
//  3 locked dropped after edge 20 (ch0,ch1 released) -> all channels active 3 edges later, done=0.
//    Re-lock -> full sequence repeats with the same offsets.
//  4 rst_n pulsed low mid-S_COUNT -> rst_out=4'b0101 asynchronously (before next edge).
//    After release, the sequence restarts with count from 0.
//  5 PWR_RST_STEP=0 -> all 4 channels release together at edge 13.
//    PWR_RST_DELAY=0 -> ch0 releases at edge 3.
//  6 PWR_RST_SOFT_EN, soft_rst_req held high 5 cycles in S_DONE -> all active next edge, done=0.
//    Release restarts the sequence: ch0 at thr0+1 edges after the first low sample.

Source files
------------

// File: rtl/pwr_rst_seq.sv
// -----------------------------------------------------------------------------
// pwr_rst_seq
//   Multi-channel power-on reset sequencer. After the clock source reports
//   lock, reset channel i is released BASE + i*STEP clock counts later,
//   channel 0 first. Losing lock puts every channel back into reset, and the
//   sequence then starts again from zero.
//
//   Optional feature macro: PWR_RST_SOFT_EN
//     When defined, the module has a soft_rst_req input. This synchronous,
//     level-sensitive request behaves like loss of lock, and it holds the
//     sequencer in S_WAIT_LOCK for as long as it stays high.
// -----------------------------------------------------------------------------
module pwr_rst_seq #(
    parameter int unsigned             MAIN_CLOCK_PERIOD    = 7,
    parameter int unsigned             CHANNEL_NUM          = 4,
    parameter int unsigned             PWR_RST_DELAY        = 100000000,
    parameter int unsigned             PWR_RST_STEP         = 1000000,
    parameter logic [CHANNEL_NUM-1:0]  PWR_RST_ACTIVE_LEVEL = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   locked,
`ifdef PWR_RST_SOFT_EN
    input  logic                   soft_rst_req,
`endif
    output logic [CHANNEL_NUM-1:0] rst_out,
    output logic                   done
);

    // Delays converted to clock counts. Division truncates.
    localparam logic [31:0] BASE_CNT = 32'(PWR_RST_DELAY / MAIN_CLOCK_PERIOD);
    localparam logic [31:0] STEP_CNT = 32'(PWR_RST_STEP / MAIN_CLOCK_PERIOD);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_COUNT     = 2'd1,
        S_DONE      = 2'd2
    } state_t;

    state_t                   state;
    logic [31:0]              count;
    logic                     lock_p0;
    logic                     lock_s;
    logic [CHANNEL_NUM-1:0]   thr_hit;
    logic [CHANNEL_NUM-1:0]   rel_now;
    logic [CHANNEL_NUM-1:0]   rel_next;
    logic                     abort;
    logic                     go;

    // Two-flop synchroniser for the asynchronous lock indication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_p0 <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            lock_p0 <= locked;
            lock_s  <= lock_p0;
        end
    end

    // Per-channel release threshold compared against the running count
    for (genvar i = 0; i < CHANNEL_NUM; i++) begin : g_thr
        localparam logic [31:0] THR = BASE_CNT + 32'(i) * STEP_CNT;
        assign thr_hit[i] = (count >= THR);
    end

    // A bit that differs from its active level is a channel already released.
    // Released channels stay released while the sequence is running.
    assign rel_now  = rst_out ^ PWR_RST_ACTIVE_LEVEL;
    assign rel_next = rel_now | thr_hit;

`ifdef PWR_RST_SOFT_EN
    assign abort = ~lock_s | soft_rst_req;
    assign go    = lock_s & ~soft_rst_req;
`else
    assign abort = ~lock_s;
    assign go    = lock_s;
`endif

    // Sequencer FSM with registered reset outputs and done flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_WAIT_LOCK;
            count   <= '0;
            rst_out <= PWR_RST_ACTIVE_LEVEL;
            done    <= 1'b0;
        end else begin
            case (state)
                S_WAIT_LOCK: begin
                    count   <= '0;
                    rst_out <= PWR_RST_ACTIVE_LEVEL;
                    done    <= 1'b0;
                    if (go) begin
                        state <= S_COUNT;
                    end
                end

                S_COUNT: begin
                    if (abort) begin
                        state   <= S_WAIT_LOCK;
                        count   <= '0;
                        rst_out <= PWR_RST_ACTIVE_LEVEL;
                        done    <= 1'b0;
                    end else begin
                        // Saturate instead of wrapping so no channel falls back
                        if (count != '1) begin
                            count <= count + 32'd1;
                        end
                        rst_out <= PWR_RST_ACTIVE_LEVEL ^ rel_next;
                        if (&rel_next) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    if (abort) begin
                        state   <= S_WAIT_LOCK;
                        count   <= '0;
                        rst_out <= PWR_RST_ACTIVE_LEVEL;
                        done    <= 1'b0;
                    end
                end

                default: begin
                    state   <= S_WAIT_LOCK;
                    count   <= '0;
                    rst_out <= PWR_RST_ACTIVE_LEVEL;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
